// File: rtl/q_mon_pkg.sv
// Shared types and defaults for the run monitor: FSM encoding, default parameters
// and the 4-bit saturating increment used for the run length.
package q_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HIT   = 2'd2
    } mon_state_t;

    localparam int DEF_RUN_LEN = 3;
    localparam int DEF_CNT_W   = 8;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/q_run_monitor_if.sv
// Sample/statistics bundle between the code source (master) and the monitor (slave).
// Carries the sample strobe, soft clear, counter readback select and all run outputs.
interface q_run_monitor_if
    import q_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic [1:0]       q_in;
    logic             q_valid;
    logic             clear;
    logic [1:0]       rd_sel;
    logic [CNT_W-1:0] rd_count;
    logic [1:0]       run_code;
    logic [3:0]       run_len;
    logic             run_hit;
    logic [7:0]       history;

    modport master (
        output q_in, q_valid, clear, rd_sel,
        input  rd_count, run_code, run_len, run_hit, history
    );

    modport slave (
        input  q_in, q_valid, clear, rd_sel,
        output rd_count, run_code, run_len, run_hit, history
    );
endinterface

// File: rtl/q_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
// Latency 1; no backpressure, inc is ignored once the counter is full.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/q_run_monitor.sv
// Tracks runs of identical 2-bit codes, per-code occurrence counts and recent history.
// Latency 1 for run/history outputs, rd_count is combinational; no backpressure, every valid sample is taken.
module q_run_monitor
    import q_mon_pkg::*;
#(
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    q_run_monitor_if.slave mon
);
    localparam logic [3:0] RUN_LEN4 = 4'(RUN_LEN);

    mon_state_t       state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [3:0]       len_q, len_d;
    logic [7:0]       hist_q, hist_d;
    logic             hit_q;
    logic             accept;
    logic [CNT_W-1:0] cnt [4];

    // clear wins over a coincident sample, so the sample never reaches a counter
    assign accept = mon.q_valid && !mon.clear;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (mon.clear),
            .inc   (accept && (mon.q_in == 2'(g))),
            .count (cnt[g])
        );
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        hist_d  = hist_q;
        if (mon.clear) begin
            state_d = IDLE;
            code_d  = 2'd0;
            len_d   = 4'd0;
            hist_d  = 8'd0;
        end else if (mon.q_valid) begin
            hist_d = {hist_q[5:0], mon.q_in};
            if ((state_q != IDLE) && (mon.q_in == code_q)) begin
                len_d   = sat_inc4(len_q);
                state_d = (len_d >= RUN_LEN4) ? HIT : TRACK;
            end else begin
                state_d = TRACK;
                code_d  = mon.q_in;
                len_d   = 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= 2'd0;
            len_q   <= 4'd0;
            hist_q  <= 8'd0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            hist_q  <= hist_d;
            hit_q   <= (state_d == HIT);
        end
    end

    assign mon.rd_count = cnt[mon.rd_sel];
    assign mon.run_code = code_q;
    assign mon.run_len  = len_q;
    assign mon.run_hit  = hit_q;
    assign mon.history  = hist_q;
endmodule

// File: tb/tb_q_run_monitor.sv
// Randomized bench for q_run_monitor against a sample-level model, plus directed literal checks.
module tb_q_run_monitor;
    localparam int RL    = 3;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    // model state: what the outputs must be, derived from the sample stream
    int         m_cnt [4];
    logic [1:0] m_code;
    int         m_len;
    logic [7:0] m_hist;
    bit         m_seen;

    q_run_monitor_if #(.CNT_W(CW)) mon ();

    q_run_monitor #(.RUN_LEN(RL), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_code = 2'd0;
        m_len  = 0;
        m_hist = 8'd0;
        m_seen = 1'b0;
    endtask

    task automatic model_update(input bit r, input bit c, input bit v, input logic [1:0] q);
        if (r || c) begin
            model_clear();
        end else if (v) begin
            if (m_cnt[q] < CMAX) m_cnt[q]++;
            if (m_seen && q == m_code) begin
                if (m_len < 15) m_len++;
            end else begin
                m_code = q;
                m_len  = 1;
            end
            m_seen = 1'b1;
            m_hist = {m_hist[5:0], q};
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v, input logic [1:0] q, input logic [1:0] sel);
        reset       = r;
        mon.clear   = c;
        mon.q_valid = v;
        mon.q_in    = q;
        mon.rd_sel  = sel;
        @(posedge clk);
        model_update(r, c, v, q);
        #1;
    endtask

    task automatic chk_counts(input string name, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int s = 0; s < 4; s++) begin
            mon.rd_sel = 2'(s);
            #1;
            chk(name, int'(mon.rd_count), e[s]);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rd_count", int'(mon.rd_count), m_cnt[mon.rd_sel]);
            chk("run_code", int'(mon.run_code), int'(m_code));
            chk("run_len",  int'(mon.run_len),  m_len);
            chk("run_hit",  int'(mon.run_hit),  int'(m_seen && m_len >= RL));
            chk("history",  int'(mon.history),  int'(m_hist));
        end
    end

    initial begin
        logic [1:0] q;
        logic [1:0] last_q;
        model_clear();
        reset = 1'b1; mon.clear = 1'b0; mon.q_valid = 1'b0; mon.q_in = 2'd0; mon.rd_sel = 2'd0;

        // reset two cycles, then idle
        step(1, 0, 0, 2'd0, 2'd0);
        step(1, 0, 0, 2'd0, 2'd0);
        cmp_en = 1'b1;
        step(0, 0, 0, 2'd0, 2'd0);
        chk("idle_len", int'(mon.run_len), 0);
        chk("idle_hit", int'(mon.run_hit), 0);
        chk("idle_hist", int'(mon.history), 0);
        chk_counts("idle_cnt", 0, 0, 0, 0);

        // 2,2,2 -> run builds to 3, hit follows the third sample
        step(0, 0, 1, 2'd2, 2'd2);
        chk("r222_len1", int'(mon.run_len), 1);
        step(0, 0, 1, 2'd2, 2'd2);
        chk("r222_len2", int'(mon.run_len), 2);
        chk("r222_hit_lo", int'(mon.run_hit), 0);
        step(0, 0, 1, 2'd2, 2'd2);
        chk("r222_len3", int'(mon.run_len), 3);
        chk("r222_hit_hi", int'(mon.run_hit), 1);
        chk("r222_hist", int'(mon.history), 8'b00101010);

        // 1,1,3 after reset
        step(1, 0, 0, 2'd0, 2'd0);
        step(0, 0, 1, 2'd1, 2'd0);
        step(0, 0, 1, 2'd1, 2'd0);
        step(0, 0, 1, 2'd3, 2'd0);
        chk("r113_code", int'(mon.run_code), 3);
        chk("r113_len", int'(mon.run_len), 1);
        chk("r113_hit", int'(mon.run_hit), 0);
        chk_counts("r113_cnt", 0, 2, 0, 1);

        // 260 zeros: counter and run length both saturate
        step(1, 0, 0, 2'd0, 2'd0);
        for (int i = 0; i < 260; i++) step(0, 0, 1, 2'd0, 2'd0);
        chk("sat_cnt", int'(mon.rd_count), 255);
        chk("sat_len", int'(mon.run_len), 15);

        // clear and sample on the same edge: sample dropped
        step(0, 0, 1, 2'd2, 2'd0);
        step(0, 1, 1, 2'd2, 2'd0);
        chk("clr_hist", int'(mon.history), 0);
        chk("clr_len", int'(mon.run_len), 0);
        chk("clr_hit", int'(mon.run_hit), 0);
        chk_counts("clr_cnt", 0, 0, 0, 0);
        step(0, 0, 1, 2'd2, 2'd2);
        chk("clr_restart_len", int'(mon.run_len), 1);

        // reset during HIT with a valid sample
        step(0, 0, 1, 2'd2, 2'd2);
        step(0, 0, 1, 2'd2, 2'd2);
        chk("pre_rst_hit", int'(mon.run_hit), 1);
        step(1, 0, 1, 2'd2, 2'd2);
        chk("rst_hit", int'(mon.run_hit), 0);
        chk("rst_len", int'(mon.run_len), 0);
        chk_counts("rst_cnt", 0, 0, 0, 0);

        // random traffic biased toward repeats so runs reach HIT and saturate
        last_q = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            bit r, c, v;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 8);
            q = ($urandom_range(0, 9) < 7) ? last_q : 2'($urandom_range(0, 3));
            last_q = q;
            step(r, c, v, q, 2'($urandom_range(0, 3)));
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/q_run_monitor.md
Q_RUN_MONITOR -- requirements
Module: q_run_monitor

Interface
REQ-001 SHALL have parameter: RUN_LEN, 3, number of consecutive identical valid codes that asserts run_hit (legal 2..15).
REQ-002 SHALL have parameter: CNT_W, 8, width of each per-code occurrence counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: q_in  input  2  result code produced by the upstream two-bit T-flip-flop stage.
REQ-006 SHALL have port: q_valid  input  1  q_in is sampled on this edge when high.
REQ-007 SHALL have port: clear  input  1  synchronous soft clear of all statistics.
REQ-008 SHALL have port: rd_sel  input  2  selects which code's counter drives rd_count.
REQ-009 SHALL have port: rd_count  output  CNT_W  occurrence count of code rd_sel.
REQ-010 SHALL have port: run_code  output  2  code of the current run.
REQ-011 SHALL have port: run_len  output  4  length of the current run, saturating at 15.
REQ-012 SHALL have port: run_hit  output  1  high while the current run length is at least RUN_LEN.
REQ-013 SHALL have port: history  output  8  last four accepted codes, newest in [1:0].

Function
REQ-014 SHALL implement FSM states IDLE (no sample since reset or clear), TRACK (run below RUN_LEN), and HIT (run at or above RUN_LEN).
REQ-015 SHALL, in IDLE with q_valid=1, go to TRACK, set run_code=q_in and set run_len=1.
REQ-016 SHALL, in TRACK or HIT with q_valid=1 and q_in==run_code, increment run_len (saturating at 15), entering HIT when the new run_len reaches RUN_LEN.
REQ-017 SHALL, in TRACK or HIT with q_valid=1 and q_in!=run_code, go to TRACK, set run_code=q_in and set run_len=1.
REQ-018 SHALL hold state, run_code, run_len, history and counters unchanged when q_valid=0.
REQ-019 SHALL drive run_hit as a registered output, high exactly when the state is HIT.
REQ-020 SHALL, on each accepted sample, increment counter[q_in] by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-021 SHALL, on each accepted sample, shift history left by 2 and insert q_in at [1:0].
REQ-022 SHALL make all outputs reflect a sample one cycle after the sampling edge (latency 1), except rd_count.
REQ-023 SHALL make rd_count a combinational mux of the registered counters, following rd_sel in the same cycle.
REQ-024 SHALL, when clear=1, return to IDLE and zero all counters, run_code, run_len and history on that edge.
REQ-025 SHALL, when clear=1 and q_valid=1 on the same edge, give clear priority and drop the sample entirely.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, enter IDLE with rd_count=0 (all counters 0), run_code=0, run_len=0, run_hit=0 and history=0.
REQ-027 SHALL give reset priority over clear and q_valid, and SHALL give reset applied mid-run the same result as reset from power-up.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE=0, TRACK=1, HIT=2) and default RUN_LEN/CNT_W constants in shared package q_mon_pkg.
REQ-029 SHALL instantiate sub-module sat_counter (parameterised width; inputs inc and clr; saturating) four times, once per code.

Verification
REQ-030 SHALL verify: reset=1 for 2 cycles, then q_valid=0 -> all outputs 0 and state IDLE.
REQ-031 SHALL verify: codes 2,2,2 valid on consecutive cycles with RUN_LEN=3 -> run_len goes 1,2,3 and run_hit rises one cycle after the third sample; history=8'b00101010.
REQ-032 SHALL verify: codes 1,1,3 -> run_code=3, run_len=1, run_hit=0; rd_sel=1 gives rd_count=2 and rd_sel=3 gives rd_count=1.
REQ-033 SHALL verify: 260 valid samples of code 0 with CNT_W=8 -> rd_count=255 (no wrap) and run_len=15.
REQ-034 SHALL verify: clear=1 and q_valid=1 with q_in=2 on the same edge -> IDLE, all counters 0, history=0, and the sample is not counted.
REQ-035 SHALL verify: reset asserted during HIT with a valid sample present -> next cycle run_hit=0, run_len=0, and counters 0.
